// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The slave modport is the loader side; the master modport is the image source
// and memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a byte-serial image big-endian into 32-bit words,
// writes them to instruction memory from address 0, verifies a trailing
// 8-bit checksum and holds the core in reset until a clean load completes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | accepting the four bytes of the current word
// WRITE | one-cycle memory write of the packed word
// CHECK | accepting the checksum byte
// DONE  | load verified, core released
// ERROR | bad length or checksum mismatch, core held
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    imem_loader_if.slave      bus,
    output logic              core_hold,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    // One bit wider than the address so a full-depth load cannot wrap to 0.
    logic [ADDR_W:0] word_cnt_q, word_cnt_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [31:0]     word_q, word_d;
    logic [ADDR_W:0] word_cnt_inc;
    logic            xfer;

    assign xfer         = bus.byte_valid && bus.byte_ready;
    assign word_cnt_inc = word_cnt_q + 1'b1;

    // Outputs are decoded from state or taken straight from registers.
    assign bus.byte_ready = (state_q == LOAD) || (state_q == CHECK);
    assign bus.imem_we    = (state_q == WRITE);
    assign bus.imem_addr  = word_cnt_q[ADDR_W-1:0];
    assign bus.imem_wdata = word_q;
    assign core_hold      = (state_q != DONE);
    assign done           = (state_q == DONE);
    assign error          = (state_q == ERROR);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            sum_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sum_q      <= sum_d;
            word_q     <= word_d;
        end
    end

    // Next-state, byte packing, checksum and word counting.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sum_d      = sum_q;
        word_d     = word_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    len_d = len;
                    if ((len == '0) || (len > DEPTH_V)) begin
                        state_d = ERROR;
                    end else begin
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        sum_d      = '0;
                        word_d     = '0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    // Shifting in from the bottom leaves the first byte in [31:24].
                    word_d     = {word_q[23:0], bus.byte_in};
                    sum_d      = sum_q + bus.byte_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? CHECK : LOAD;
            end
            CHECK: begin
                if (xfer) begin
                    state_d = (bus.byte_in == sum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for the program loader.
module tb_imem_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [ADDR_W:0] len;
    logic            core_hold;
    logic            done;
    logic            error;

    int checks;
    int errors;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bus       (bus.slave),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write observer, sampled on the falling edge.
    logic [31:0] mem_obs [0:DEPTH-1];
    int          wr_cnt;
    int          wr_at0;
    int          last_addr;
    int          rdy_in_we;
    bit          ready_seen;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            mem_obs[bus.imem_addr] = bus.imem_wdata;
            wr_cnt++;
            last_addr = int'(bus.imem_addr);
            if (bus.imem_addr == '0) wr_at0++;
            if (bus.byte_ready !== 1'b0) rdy_in_we++;
        end
        if (bus.byte_ready === 1'b1) ready_seen = 1'b1;
    end

    task automatic clear_obs();
        for (int i = 0; i < DEPTH; i++) mem_obs[i] = 32'hDEADBEEF;
        wr_cnt     = 0;
        wr_at0     = 0;
        last_addr  = -1;
        rdy_in_we  = 0;
        ready_seen = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=%02h ready never rose", b);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.byte_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bus.imem_wdata); end
        checks++; if ({core_hold, done, error} !== 3'b100) begin errors++; $display("FAIL reset_flags hold/done/err got %b exp 100", {core_hold, done, error}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_load(input string name);
        logic [7:0] img [0:7];
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA0, 8'h00, 8'h00, 8'h00};
        clear_obs();
        pulse_start(9'd2);
        checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL %s start_to_ready got %b exp 1", name, bus.byte_ready); end
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i]);
            if (i == 3) begin
                checks++;
                if ({bus.imem_we, bus.byte_ready, bus.imem_addr} !== {2'b10, 8'h00}) begin
                    errors++;
                    $display("FAIL %s write_latency we/ready/addr got %b/%b/%h exp 1/0/00", name, bus.imem_we, bus.byte_ready, bus.imem_addr);
                end
            end
        end
        send_byte(8'hB4);
        checks++; if ({core_hold, done, error} !== 3'b010) begin errors++; $display("FAIL %s done_flags hold/done/err got %b exp 010", name, {core_hold, done, error}); end
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL %s write_count got %0d exp 2", name, wr_cnt); end
        checks++; if (mem_obs[0] !== 32'h12345678) begin errors++; $display("FAIL %s word0 got %h exp 12345678", name, mem_obs[0]); end
        checks++; if (mem_obs[1] !== 32'hA0000000) begin errors++; $display("FAIL %s word1 got %h exp a0000000", name, mem_obs[1]); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] img [0:7];
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA0, 8'h00, 8'h00, 8'h00};
        clear_obs();
        pulse_start(9'd2);
        for (int i = 0; i < 8; i++) send_byte(img[i]);
        send_byte(8'h00);
        checks++; if ({core_hold, done, error} !== 3'b101) begin errors++; $display("FAIL badsum_flags hold/done/err got %b exp 101", {core_hold, done, error}); end
        checks++; if (wr_cnt !== 2 || mem_obs[0] !== 32'h12345678 || mem_obs[1] !== 32'hA0000000) begin
            errors++; $display("FAIL badsum_writes cnt=%0d w0=%h w1=%h exp 2/12345678/a0000000", wr_cnt, mem_obs[0], mem_obs[1]);
        end
    endtask

    task automatic test_bad_length(input logic [ADDR_W:0] l);
        clear_obs();
        pulse_start(l);
        checks++; if ({core_hold, done, error} !== 3'b101) begin errors++; $display("FAIL badlen_%0d flags got %b exp 101", l, {core_hold, done, error}); end
        bus.byte_in    = 8'h55;
        bus.byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        checks++; if (ready_seen || wr_cnt != 0) begin errors++; $display("FAIL badlen_%0d activity ready_seen=%b writes=%0d exp 0/0", l, ready_seen, wr_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] img [0:7];
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA0, 8'h00, 8'h00, 8'h00};
        clear_obs();
        pulse_start(9'd2);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                checks++;
                if ({bus.imem_we, bus.byte_ready} !== 2'b10) begin
                    errors++; $display("FAIL bp_write_ready we/ready got %b exp 10", {bus.imem_we, bus.byte_ready});
                end
            end else if (i % 2 == 1) begin
                repeat (2) @(negedge clk);
            end
            send_byte(img[i]);
        end
        repeat (2) @(negedge clk);
        send_byte(8'hB4);
        checks++; if ({core_hold, done, error} !== 3'b010) begin errors++; $display("FAIL bp_flags got %b exp 010", {core_hold, done, error}); end
        checks++; if (wr_cnt !== 2 || mem_obs[0] !== 32'h12345678 || mem_obs[1] !== 32'hA0000000 || rdy_in_we != 0) begin
            errors++; $display("FAIL bp_writes cnt=%0d w0=%h w1=%h rdy_in_we=%0d exp 2/12345678/a0000000/0", wr_cnt, mem_obs[0], mem_obs[1], rdy_in_we);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] img [0:5];
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA0, 8'h00};
        clear_obs();
        pulse_start(9'd2);
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bus.byte_ready, core_hold, done, error} !== 4'b0100) begin errors++; $display("FAIL rstmid_flags ready/hold/done/err got %b exp 0100", {bus.byte_ready, core_hold, done, error}); end
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        checks++; if (wr_cnt !== 1 || mem_obs[0] !== 32'h12345678) begin errors++; $display("FAIL rstmid_writes cnt=%0d w0=%h exp 1/12345678", wr_cnt, mem_obs[0]); end
        test_good_load("after_rst");
    endtask

    task automatic test_full_depth();
        logic [31:0] w;
        logic [7:0]  sum;
        clear_obs();
        sum = 8'h00;
        pulse_start(9'd256);
        for (int k = 0; k < DEPTH; k++) begin
            w = 32'h1000_0000 + 32'(k);
            for (int j = 3; j >= 0; j--) begin
                sum = sum + w[j*8 +: 8];
                send_byte(w[j*8 +: 8]);
            end
        end
        send_byte(sum);
        checks++; if ({core_hold, done, error} !== 3'b010) begin errors++; $display("FAIL full_flags got %b exp 010", {core_hold, done, error}); end
        checks++; if (wr_cnt !== DEPTH || last_addr !== DEPTH - 1 || wr_at0 !== 1) begin
            errors++; $display("FAIL full_addr cnt=%0d last=%0d at0=%0d exp 256/255/1", wr_cnt, last_addr, wr_at0);
        end
        checks++; if (mem_obs[0] !== 32'h10000000 || mem_obs[DEPTH-1] !== 32'h100000FF) begin
            errors++; $display("FAIL full_data w0=%h wlast=%h exp 10000000/100000ff", mem_obs[0], mem_obs[DEPTH-1]);
        end
        pulse_start(9'd2);
        checks++; if ({core_hold, done, bus.byte_ready} !== 3'b101) begin errors++; $display("FAIL restart hold/done/ready got %b exp 101", {core_hold, done, bus.byte_ready}); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        start          = 1'b0;
        len            = '0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        clear_obs();
        @(negedge clk);
        test_reset();
        test_good_load("good");
        test_bad_checksum();
        test_bad_length(9'd0);
        test_bad_length(9'd257);
        test_backpressure();
        test_reset_mid();
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the pipeline runs. It sits upstream of the instruction memory write port and is the writer end of the IF-stage fetch path. It accepts a byte-serial program image over a valid/ready stream, packs the bytes into 32-bit instruction words, writes them to consecutive addresses from 0, and verifies a trailing checksum byte. It holds the core in reset until a load completes cleanly.

## Interface
- DEPTH, 256, instruction memory depth in words
- ADDR_W, 8, word address width; DEPTH ≤ 2^ADDR_W

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERROR
- len  in  ADDR_W+1  number of words to load; sampled on the start cycle
- byte_in  in  8  stream data
- byte_valid  in  1  stream data valid
- byte_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction memory write enable, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  instruction word
- core_hold  out  1  holds the pipeline PC and registers in reset
- done  out  1  load completed and checksum matched
- error  out  1  load rejected: bad length or checksum mismatch

## Operation
- A byte transfers on any cycle where byte_valid and byte_ready are both 1. Bytes offered while byte_ready is 0 are not consumed.
- States are IDLE, LOAD, WRITE, CHECK, DONE and ERROR.
- **IDLE:** on start, the loader latches len.
  - If len is 0 or len > DEPTH, go to ERROR.
  - Otherwise clear the word counter, byte counter and checksum, then go to LOAD.
- **LOAD:** byte_ready is 1.
  - Bytes are packed big-endian. The first byte goes to [31:24] and the fourth to [7:0], so the opcode field [31:28] comes from the first byte.
  - Each accepted byte is added to an 8-bit running sum, mod 256.
  - After the 4th byte of a word is accepted, go to WRITE.
- **WRITE:** lasts exactly one cycle.
  - imem_we is 1, imem_addr holds the word counter, imem_wdata holds the packed word, and byte_ready is 0.
  - The word counter then increments.
  - If the count now equals the latched len, go to CHECK; otherwise go back to LOAD.
- **CHECK:** byte_ready is 1 and the loader accepts one byte.
  - If the byte equals the running sum, go to DONE; otherwise go to ERROR.
- **DONE:** done is 1 and core_hold is 0. On start, begin a new load (same rules as IDLE), which reasserts core_hold and clears done.
- **ERROR:** error is 1 and core_hold stays 1. On start, begin a new load the same way.
- start is ignored in LOAD, WRITE and CHECK.
- Words already written before an ERROR stay in memory. The loader does not roll them back.
- When len = DEPTH, the last write goes to address DEPTH-1. The word counter must never wrap to 0 before reaching CHECK.

## Timing
- Reset values:
  - state IDLE
  - byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - core_hold 1, done 0, error 0
- All outputs are registered or decoded from state only. There is no combinational path from byte_valid to byte_ready.
- Latency from start to first byte_ready is 1 cycle: start at cycle N, LOAD at N+1.
- Latency from the 4th byte accepted at cycle N to imem_we is 1: imem_we is high at N+1, and byte_ready is high again at N+2.
- Minimum load time for L words is 1 + 5L + 1 cycles from start to done.
- Latency from checksum byte accepted at N to done or error is 1: the flag rises at N+1, and core_hold falls at N+1 on success.
- Gaps in byte_valid stall the loader indefinitely with no timeout. Counters and the partial word are held.
- rst mid-operation takes effect at the next edge:
  - Return to IDLE and discard any partial word.
  - No write is issued that cycle or later.
  - core_hold is 1.

## Test plan
- **Good load:** len=2, stream 12 34 56 78 A0 00 00 00 then checksum B4.
  - Expect writes addr0=0x12345678 and addr1=0xA0000000, each as a single-cycle imem_we.
  - Expect done=1 and core_hold=0 one cycle after the B4 byte.
- **Bad checksum:** same stream but checksum 00 → both words written, error=1, done=0, core_hold=1.
- **Bad length:** start with len=0, and separately with len=DEPTH+1 → error=1 the cycle after the ERROR transition, byte_ready never 1, no writes.
- **Backpressure:** byte_valid toggled 1-0-0-1 between bytes, plus bytes offered during WRITE.
  - Expect no byte dropped or duplicated.
  - Expect byte_ready=0 during WRITE and the same memory contents as the good-load case.
- **Reset mid-load:** rst after 6 bytes of a len=2 load.
  - Expect only addr0 written, then IDLE with core_hold=1, done=0 and error=0.
  - A subsequent full good load succeeds.
- **Full depth and restart:** len=DEPTH with incrementing words → last write at addr DEPTH-1, then done=1. A start pulse in DONE reasserts core_hold and clears done on the next cycle.
